// File: rtl/match_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : match_controller_pkg
//  Description : Shared constants for the round/match sequencer:
//                state encoding, match-winner codes and default timings.
//  Revision    : 1.0 - initial release
// ============================================================================
package match_controller_pkg;

  // FSM state encoding, visible on the state output port
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN  = 3'd1;
  localparam logic [2:0] ST_FIGHT      = 3'd2;
  localparam logic [2:0] ST_ROUND_END  = 3'd3;
  localparam logic [2:0] ST_MATCH_OVER = 3'd4;

  // match_winner codes
  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_P1   = 2'b01;
  localparam logic [1:0] MW_P2   = 2'b10;

  // Default timings and series length
  localparam int DEF_ROUNDS_TO_WIN   = 2;
  localparam int DEF_COUNTDOWN_TICKS = 3;
  localparam int DEF_END_HOLD_TICKS  = 4;

  // round_num never advances past this round
  localparam logic [1:0] MAX_ROUND = 2'd3;

endpackage : match_controller_pkg
`default_nettype wire

// File: rtl/match_controller_tick_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tick_down_counter
//  Description : 4-bit loadable down-counter advanced by a tick enable.
//                hit_one_o flags the value from which the next tick expires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_down_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic [3:0] count_o,
  output logic       hit_one_o
);

  logic [3:0] count_q;

  // Load has priority over decrement; the counter never wraps below zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 4'd0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != 4'd0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign count_o   = count_q;
  assign hit_one_o = (count_q == 4'd1);

endmodule : tick_down_counter
`default_nettype wire

// File: rtl/match_controller.sv
`default_nettype none
// ============================================================================
//  Module      : match_controller
//  Description : Round/match sequencer for the fighting game. Runs the
//                pre-round countdown, opens the fight window, scores rounds
//                and declares the winner of a best-of-N series.
//  Revision    : 1.0 - initial release
// ============================================================================
module match_controller
  import match_controller_pkg::*;
#(
  parameter int ROUNDS_TO_WIN   = DEF_ROUNDS_TO_WIN,
  parameter int COUNTDOWN_TICKS = DEF_COUNTDOWN_TICKS,
  parameter int END_HOLD_TICKS  = DEF_END_HOLD_TICKS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       winner1,
  input  logic       winner2,
  output logic       round_reset,
  output logic       fight_en,
  output logic [2:0] state,
  output logic [3:0] countdown,
  output logic [1:0] round_num,
  output logic [1:0] score1,
  output logic [1:0] score2,
  output logic [1:0] match_winner
);

  localparam logic [1:0] c_RTW  = 2'(ROUNDS_TO_WIN);
  localparam logic [3:0] c_CD   = 4'(COUNTDOWN_TICKS);
  localparam logic [3:0] c_HOLD = 4'(END_HOLD_TICKS);

  logic [2:0] state_q, state_d;
  logic       start_q;
  logic [1:0] round_q, round_d;
  logic [1:0] score1_q, score1_d;
  logic [1:0] score2_q, score2_d;
  logic [1:0] mw_q, mw_d;
  logic       draw_q, draw_d;

  logic       w_start_rise;
  logic       w_cd_load, w_cd_dec, w_cd_hit_one;
  logic       w_hold_load, w_hold_dec, w_hold_hit_one;
  logic [3:0] w_cd_count, w_hold_count;

  assign w_start_rise = start & ~start_q;

  // Pre-round countdown, shown on the countdown output
  tick_down_counter u_countdown (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (w_cd_load),
    .load_val_i (c_CD),
    .dec_i      (w_cd_dec),
    .count_o    (w_cd_count),
    .hit_one_o  (w_cd_hit_one)
  );

  // Round-end result hold timer
  tick_down_counter u_hold (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (w_hold_load),
    .load_val_i (c_HOLD),
    .dec_i      (w_hold_dec),
    .count_o    (w_hold_count),
    .hit_one_o  (w_hold_hit_one)
  );

  // State register plus score/round bookkeeping and start edge detector
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      round_q  <= 2'd1;
      score1_q <= 2'd0;
      score2_q <= 2'd0;
      mw_q     <= MW_NONE;
      draw_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      round_q  <= round_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      mw_q     <= mw_d;
      draw_q   <= draw_d;
    end
  end

  // Next-state logic: transitions, counter control and score updates
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    mw_d        = mw_q;
    draw_d      = draw_q;
    w_cd_load   = 1'b0;
    w_cd_dec    = 1'b0;
    w_hold_load = 1'b0;
    w_hold_dec  = 1'b0;

    case (state_q)
      ST_IDLE, ST_MATCH_OVER: begin
        // A new match starts from either resting state
        if (w_start_rise) begin
          state_d   = ST_COUNTDOWN;
          w_cd_load = 1'b1;
          round_d   = 2'd1;
          score1_d  = 2'd0;
          score2_d  = 2'd0;
          mw_d      = MW_NONE;
          draw_d    = 1'b0;
        end
      end

      ST_COUNTDOWN: begin
        if (tick) begin
          w_cd_dec = 1'b1;
          if (w_cd_hit_one) begin
            state_d = ST_FIGHT;
          end
        end
      end

      ST_FIGHT: begin
        // Either flag ends the round; both together is a double KO (draw)
        if (winner1 | winner2) begin
          state_d     = ST_ROUND_END;
          w_hold_load = 1'b1;
          draw_d      = winner1 & winner2;
          if (winner1 && !winner2 && (score1_q != c_RTW)) begin
            score1_d = score1_q + 2'd1;
          end
          if (winner2 && !winner1 && (score2_q != c_RTW)) begin
            score2_d = score2_q + 2'd1;
          end
        end
      end

      ST_ROUND_END: begin
        if (tick && (w_hold_count != 4'd0)) begin
          w_hold_dec = 1'b1;
          if (w_hold_hit_one) begin
            if (score1_q == c_RTW) begin
              state_d = ST_MATCH_OVER;
              mw_d    = MW_P1;
            end else if (score2_q == c_RTW) begin
              state_d = ST_MATCH_OVER;
              mw_d    = MW_P2;
            end else begin
              // A drawn round is replayed under the same round number
              state_d   = ST_COUNTDOWN;
              w_cd_load = 1'b1;
              if (!draw_q && (round_q != MAX_ROUND)) begin
                round_d = round_q + 2'd1;
              end
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode, driven purely from registered state
  always_comb begin
    round_reset = (state_q != ST_FIGHT);
    fight_en    = (state_q == ST_FIGHT);
  end

  assign state        = state_q;
  assign countdown    = w_cd_count;
  assign round_num    = round_q;
  assign score1       = score1_q;
  assign score2       = score2_q;
  assign match_winner = mw_q;

endmodule : match_controller
`default_nettype wire

// File: tb/tb_match_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_match_controller
//  Description : Directed self-checking bench for match_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_match_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       winner1 = 1'b0;
  logic       winner2 = 1'b0;
  logic       round_reset;
  logic       fight_en;
  logic [2:0] state;
  logic [3:0] countdown;
  logic [1:0] round_num;
  logic [1:0] score1;
  logic [1:0] score2;
  logic [1:0] match_winner;

  int n_checks = 0;
  int n_errors = 0;

  match_controller dut (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .start        (start),
    .winner1      (winner1),
    .winner2      (winner2),
    .round_reset  (round_reset),
    .fight_en     (fight_en),
    .state        (state),
    .countdown    (countdown),
    .round_num    (round_num),
    .score1       (score1),
    .score2       (score2),
    .match_winner (match_winner)
  );

  always #5 clock = ~clock;

  // One clock: inputs change and outputs are sampled on the falling edge
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse_tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full snapshot of every output; round_reset/fight_en follow from state
  task automatic check_all(input string tag, input logic [2:0] st, input logic [3:0] cd,
                           input logic [1:0] rn, input logic [1:0] s1,
                           input logic [1:0] s2, input logic [1:0] mw);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".countdown"}, 32'(countdown), 32'(cd));
    check({tag, ".round_num"}, 32'(round_num), 32'(rn));
    check({tag, ".score1"}, 32'(score1), 32'(s1));
    check({tag, ".score2"}, 32'(score2), 32'(s2));
    check({tag, ".match_winner"}, 32'(match_winner), 32'(mw));
    check({tag, ".fight_en"}, 32'(fight_en), (st == 3'd2) ? 32'd1 : 32'd0);
    check({tag, ".round_reset"}, 32'(round_reset), (st == 3'd2) ? 32'd0 : 32'd1);
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    check_all("reset", 3'd0, 4'd0, 2'd1, 2'd0, 2'd0, 2'd0);

    // Start pulse -> COUNTDOWN loaded with 3
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_all("start", 3'd1, 4'd3, 2'd1, 2'd0, 2'd0, 2'd0);

    // Cycles without tick hold the countdown
    cyc();
    cyc();
    check_all("cd_hold", 3'd1, 4'd3, 2'd1, 2'd0, 2'd0, 2'd0);
    ticks(2);
    check_all("cd_at1", 3'd1, 4'd1, 2'd1, 2'd0, 2'd0, 2'd0);
    pulse_tick();
    check_all("fight1", 3'd2, 4'd0, 2'd1, 2'd0, 2'd0, 2'd0);

    // tick ignored in FIGHT
    ticks(2);
    check_all("fight_tick", 3'd2, 4'd0, 2'd1, 2'd0, 2'd0, 2'd0);

    // Player 1 wins round 1
    winner1 = 1'b1;
    cyc();
    winner1 = 1'b0;
    check_all("r1_end", 3'd3, 4'd0, 2'd1, 2'd1, 2'd0, 2'd0);
    ticks(3);
    check_all("r1_hold", 3'd3, 4'd0, 2'd1, 2'd1, 2'd0, 2'd0);
    pulse_tick();
    check_all("r2_cd", 3'd1, 4'd3, 2'd2, 2'd1, 2'd0, 2'd0);

    // Double KO in round 2: no score, round replayed
    ticks(3);
    check_all("r2_fight", 3'd2, 4'd0, 2'd2, 2'd1, 2'd0, 2'd0);
    winner1 = 1'b1;
    winner2 = 1'b1;
    cyc();
    winner1 = 1'b0;
    winner2 = 1'b0;
    check_all("draw_end", 3'd3, 4'd0, 2'd2, 2'd1, 2'd0, 2'd0);
    ticks(4);
    check_all("draw_cd", 3'd1, 4'd3, 2'd2, 2'd1, 2'd0, 2'd0);

    // Player 2 takes the replayed round 2
    ticks(3);
    winner2 = 1'b1;
    cyc();
    winner2 = 1'b0;
    check_all("r2_p2", 3'd3, 4'd0, 2'd2, 2'd1, 2'd1, 2'd0);
    ticks(4);
    check_all("r3_cd", 3'd1, 4'd3, 2'd3, 2'd1, 2'd1, 2'd0);

    // Player 1 takes round 3 and the match
    ticks(3);
    winner1 = 1'b1;
    cyc();
    winner1 = 1'b0;
    check_all("r3_end", 3'd3, 4'd0, 2'd3, 2'd2, 2'd1, 2'd0);
    ticks(4);
    check_all("match_over", 3'd4, 4'd0, 2'd3, 2'd2, 2'd1, 2'd1);

    // Winner flags ignored in MATCH_OVER
    winner2 = 1'b1;
    cyc();
    winner2 = 1'b0;
    check_all("mo_ignore", 3'd4, 4'd0, 2'd3, 2'd2, 2'd1, 2'd1);

    // Held start: one rematch, countdown not reloaded while held
    start = 1'b1;
    cyc();
    check_all("rematch", 3'd1, 4'd3, 2'd1, 2'd0, 2'd0, 2'd0);
    winner1 = 1'b1;
    winner2 = 1'b0;
    pulse_tick();
    cyc();
    winner1 = 1'b0;
    check_all("held_cd", 3'd1, 4'd2, 2'd1, 2'd0, 2'd0, 2'd0);
    ticks(2);
    check_all("held_fight", 3'd2, 4'd0, 2'd1, 2'd0, 2'd0, 2'd0);
    cyc();
    check_all("held_stay", 3'd2, 4'd0, 2'd1, 2'd0, 2'd0, 2'd0);
    start = 1'b0;

    // Reset mid-ROUND_END
    winner2 = 1'b1;
    cyc();
    winner2 = 1'b0;
    pulse_tick();
    check_all("pre_rst_re", 3'd3, 4'd0, 2'd1, 2'd0, 2'd1, 2'd0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_all("rst_re", 3'd0, 4'd0, 2'd1, 2'd0, 2'd0, 2'd0);

    // Reset mid-COUNTDOWN and mid-FIGHT
    start = 1'b1;
    cyc();
    start = 1'b0;
    pulse_tick();
    check_all("pre_rst_cd", 3'd1, 4'd2, 2'd1, 2'd0, 2'd0, 2'd0);
    ticks(2);
    check_all("pre_rst_f", 3'd2, 4'd0, 2'd1, 2'd0, 2'd0, 2'd0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_all("rst_fight", 3'd0, 4'd0, 2'd1, 2'd0, 2'd0, 2'd0);

    // start_rise outside IDLE/MATCH_OVER is ignored; countdown continues
    start = 1'b1;
    cyc();
    start = 1'b0;
    pulse_tick();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_all("cd_start_ign", 3'd1, 4'd2, 2'd1, 2'd0, 2'd0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_match_controller
`default_nettype wire
